shift_left_seq: RTL and testbench

- Sequential left-shift engine, complementary to the team's combinational 5-bit-lane right shifter.
- Accepts one 50-bit word with a lane shift count and a 5-bit fill value over a valid/ready handshake.
- Shifts the word left one 5-bit lane per clock, inserting the fill value into lane 0 each step.
- Presents the result over an output valid/ready handshake. It sits on the pack side of the lane datapath.

---
 rtl/shift_left_seq.sv | 110 +++++++++++
 tb/tb_shift_left_seq.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/shift_left_seq.sv
// rtl/shift_left_seq.sv - sequential lane-wise left shifter with valid/ready in and out
// Shifts one CHUNK-wide lane per clock, inserting a latched fill value into lane 0.
module shift_left_seq #(
    parameter int WIDTH     = 50,
    parameter int CHUNK     = 5,
    parameter int SHIFT_W   = 3,
    parameter int MAX_SHIFT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in,
    input  logic [SHIFT_W-1:0] shift,
    input  logic [CHUNK-1:0]   fill,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out,
    output logic               out_err,
    output logic               busy
);
    localparam int LANES = WIDTH / CHUNK;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [SHIFT_W-1:0] count_q, count_d;
    logic [CHUNK-1:0]   fill_q, fill_d;
    logic               err_q, err_d;
    logic [WIDTH-1:0]   fill_rep;

    always_comb begin
        fill_rep = '0;
        for (int i = 0; i < LANES; i++) begin
            fill_rep[i*CHUNK +: CHUNK] = fill;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            count_q <= '0;
            fill_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            count_q <= count_d;
            fill_q  <= fill_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        count_d = count_q;
        fill_d  = fill_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    fill_d = fill;
                    if (shift == '0) begin
                        data_d  = in;
                        err_d   = 1'b0;
                        state_d = S_DONE;
                    end else if (shift <= SHIFT_W'(MAX_SHIFT)) begin
                        data_d  = in;
                        count_d = shift;
                        err_d   = 1'b0;
                        state_d = S_SHIFT;
                    end else begin
                        // Out-of-range request still completes, flagged, with a recognisable pattern.
                        data_d  = fill_rep;
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_SHIFT: begin
                data_d  = {data_q[WIDTH-CHUNK-1:0], fill_q};
                count_d = count_q - SHIFT_W'(1);
                if (count_q == SHIFT_W'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
        busy      = (state_q != S_IDLE);
        out       = out_valid ? data_q : '0;
        out_err   = out_valid ? err_q : 1'b0;
    end
endmodule

// File: tb/tb_shift_left_seq.sv
// tb/tb_shift_left_seq.sv - randomized and directed bench for shift_left_seq against a lane model
module tb_shift_left_seq;
    localparam int WIDTH = 50;
    localparam int CHUNK = 5;
    localparam int LANES = 10;
    localparam int MAXS  = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_w = '0;
    logic [2:0]       shift_w = '0;
    logic [CHUNK-1:0] fill_w = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_w;
    logic             out_err;
    logic             busy;

    int checks = 0;
    int errors = 0;

    shift_left_seq dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in(in_w), .shift(shift_w), .fill(fill_w),
        .out_valid(out_valid), .out_ready(out_ready),
        .out(out_w), .out_err(out_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: shifting left by s lanes is multiplication by 32**s, truncated to the word.
    function automatic logic [WIDTH-1:0] model_out(input logic [WIDTH-1:0] d, input int s,
                                                   input logic [CHUNK-1:0] f);
        logic [WIDTH-1:0] r;
        r = '0;
        if (s > MAXS) begin
            for (int i = 0; i < LANES; i++) r = r | (WIDTH'(f) << (CHUNK * i));
        end else begin
            r = d;
            for (int i = 0; i < s; i++) r = (r * WIDTH'(32)) + WIDTH'(f);
        end
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] rand50();
        return WIDTH'({$urandom(), $urandom()});
    endfunction

    // Issues one request, scrambles the inputs afterwards, and waits for out_valid.
    task automatic do_req(input string tag, input logic [WIDTH-1:0] d, input int s,
                          input logic [CHUNK-1:0] f);
        int lat;
        int exp_lat;
        exp_lat = (s == 0 || s > MAXS) ? 1 : s + 1;
        @(negedge clk);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_w     = d;
        shift_w  = 3'(s);
        fill_w   = f;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_w     = rand50();
        shift_w  = 3'($urandom_range(0, 7));
        fill_w   = ~f;
        lat = 1;
        while (!out_valid && lat < 20) begin
            chk({tag, "_busy_wait"}, 64'(busy), 64'd1);
            @(posedge clk);
            #1;
            fill_w = 5'($urandom());
            lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_out"}, 64'(out_w), 64'(model_out(d, s, f)));
        chk({tag, "_err"}, 64'(out_err), 64'(s > MAXS));
        chk({tag, "_ready_low"}, 64'(in_ready), 64'd0);
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, "_idle_ready"}, 64'(in_ready), 64'd1);
        chk({tag, "_idle_valid"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        logic [WIDTH-1:0] d;
        logic [WIDTH-1:0] held;
        int s;

        // Reset with random inputs
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid  = 1'($urandom());
            out_ready = 1'($urandom());
            in_w      = rand50();
            shift_w   = 3'($urandom());
            fill_w    = 5'($urandom());
        end
        chk("rst_hold_valid", 64'(out_valid), 64'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out", 64'(out_w), 64'd0);
        chk("rst_out_err", 64'(out_err), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);

        // Zero shift
        do_req("zero", 50'h3_FFFF_0000_1234, 0, 5'h1F);
        chk("zero_literal", 64'(out_w), 64'h3_FFFF_0000_1234);
        drain("zero");

        // Legal shifts
        for (int k = 1; k <= MAXS; k++) begin
            do_req($sformatf("legal%0d", k), 50'h1, k, 5'h0A);
            if (k == 1) chk("legal1_literal", 64'(out_w), 64'h2A);
            if (k == 4) chk("legal4_literal", 64'(out_w), 64'((1 << 20) | 20'h5294A));
            drain($sformatf("legal%0d", k));
        end

        // Illegal shifts
        for (int k = 5; k <= 7; k++) begin
            do_req($sformatf("illegal%0d", k), rand50(), k, 5'h13);
            chk($sformatf("illegal%0d_lanes", k), 64'(out_w), 64'h2_739C_E739_CE73);
            drain($sformatf("illegal%0d", k));
        end

        // Backpressure
        out_ready = 1'b0;
        d = rand50();
        do_req("bp", d, 2, 5'h07);
        held = out_w;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_w     = rand50();
            shift_w  = 3'($urandom());
            fill_w   = 5'($urandom());
            @(posedge clk);
            #1;
            chk($sformatf("bp_hold_out%0d", i), 64'(out_w), 64'(held));
            chk($sformatf("bp_hold_valid%0d", i), 64'(out_valid), 64'd1);
            chk($sformatf("bp_hold_ready%0d", i), 64'(in_ready), 64'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_final_out", 64'(out_w), 64'(model_out(d, 2, 5'h07)));
        drain("bp");

        // Reset during SHIFT with two lanes still to go
        @(negedge clk);
        in_valid = 1'b1;
        in_w     = rand50();
        shift_w  = 3'd2;
        fill_w   = 5'h11;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("mid_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_out", 64'(out_w), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        d = rand50();
        do_req("post_rst", d, 1, 5'h05);
        drain("post_rst");

        // Randomized requests
        for (int i = 0; i < 40; i++) begin
            d = rand50();
            s = $urandom_range(0, 7);
            out_ready = 1'($urandom());
            do_req($sformatf("rnd%0d_s%0d", i, s), d, s, 5'($urandom()));
            drain($sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
